// File: rtl/conv_psum_accumulator.sv
// Per-lane partial-sum accumulator downstream of the MAC array.
// Seeds each pixel with a latched bias, saturates, and emits one result per pixel.
module conv_psum_accumulator #(
   parameter int LANES  = 8,
   parameter int PSUM_W = 24,
   parameter int BIAS_W = 32,
   parameter int ACC_W  = 32,
   parameter int PIX_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [PIX_W-1:0]        cfg_total_pixels,
   input  logic                    bias_valid,
   input  logic [LANES*BIAS_W-1:0] bias_data,
   input  logic                    conv_valid_in,
   input  logic                    conv_last_channel,
   input  logic [LANES*PSUM_W-1:0] psum_in,
   output logic                    acc_valid_out,
   output logic [LANES*ACC_W-1:0]  acc_data_out,
   output logic                    frame_done,
   output logic                    ovf_sticky,
   output logic                    proto_err
);

   localparam int SW = ACC_W + 1;

   typedef enum logic [1:0] {IDLE, ARMED, ACCUM} state_t;

   state_t                  state;
   logic [LANES*BIAS_W-1:0] bias_q;
   logic [LANES*ACC_W-1:0]  acc_q;
   logic [LANES*ACC_W-1:0]  acc_nxt;
   logic [PIX_W-1:0]        cnt;
   logic [PIX_W-1:0]        total_q;
   logic [PIX_W-1:0]        cnt_base;
   logic [PIX_W-1:0]        cnt_inc;
   logic [PIX_W-1:0]        total_sel;
   logic [PIX_W-1:0]        total_eff;
   logic                    first;
   logic                    emit;
   logic                    frame_hit;
   logic                    lane_ovf;
   logic                    err_now;
   logic signed [SW-1:0]    base;
   logic signed [SW-1:0]    sum;

   assign first = (state != ACCUM);
   assign emit  = conv_valid_in & conv_last_channel;

   // A bias load restarts the frame, so the emit in that cycle counts as pixel 1.
   assign cnt_base  = bias_valid ? '0 : cnt;
   assign total_sel = bias_valid ? cfg_total_pixels : total_q;
   assign total_eff = (total_sel == '0) ? PIX_W'(1) : total_sel;
   assign cnt_inc   = cnt_base + 1'b1;
   assign frame_hit = (cnt_inc == total_eff);

   assign err_now = (conv_last_channel & ~conv_valid_in)
                  | (conv_valid_in & (state == IDLE) & ~bias_valid)
                  | (bias_valid & (state == ACCUM));

   // Per-lane seed selection, widened add and saturation for the current beat.
   always_comb begin
      acc_nxt  = '0;
      lane_ovf = 1'b0;
      base     = '0;
      sum      = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!first)
            base = SW'($signed(acc_q[i*ACC_W +: ACC_W]));
         else if (bias_valid)
            base = SW'($signed(bias_data[i*BIAS_W +: BIAS_W]));
         else if (state == IDLE)
            base = '0;
         else
            base = SW'($signed(bias_q[i*BIAS_W +: BIAS_W]));
         sum = base + SW'($signed(psum_in[i*PSUM_W +: PSUM_W]));
         if (sum[SW-1] != sum[SW-2]) begin
            lane_ovf = 1'b1;
            acc_nxt[i*ACC_W +: ACC_W] = {sum[SW-1], {(ACC_W-1){~sum[SW-1]}}};
         end else begin
            acc_nxt[i*ACC_W +: ACC_W] = sum[ACC_W-1:0];
         end
      end
   end

   // Control FSM, accumulators, pixel counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bias_q        <= '0;
         acc_q         <= '0;
         cnt           <= '0;
         total_q       <= '0;
         acc_valid_out <= 1'b0;
         acc_data_out  <= '0;
         frame_done    <= 1'b0;
         ovf_sticky    <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         acc_valid_out <= 1'b0;
         frame_done    <= 1'b0;
         if (bias_valid) begin
            bias_q     <= bias_data;
            total_q    <= cfg_total_pixels;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
         end
         if (conv_valid_in) begin
            acc_q <= acc_nxt;
            if (lane_ovf)
               ovf_sticky <= 1'b1;
         end
         if (emit) begin
            acc_valid_out <= 1'b1;
            acc_data_out  <= acc_nxt;
            frame_done    <= frame_hit;
            cnt           <= frame_hit ? '0 : cnt_inc;
         end
         if (err_now)
            proto_err <= 1'b1;
         if (conv_valid_in)
            state <= conv_last_channel ? ARMED : ACCUM;
         else if (bias_valid && state != ACCUM)
            state <= ARMED;
      end
   end

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Directed testbench for conv_psum_accumulator.
// Hand-computed expectations, one checking task, one summary line.
module tb_conv_psum_accumulator;

   logic          clk;
   logic          rst_n;
   logic [15:0]   cfg_total_pixels;
   logic          bias_valid;
   logic [255:0]  bias_data;
   logic          conv_valid_in;
   logic          conv_last_channel;
   logic [191:0]  psum_in;
   logic          acc_valid_out;
   logic [255:0]  acc_data_out;
   logic          frame_done;
   logic          ovf_sticky;
   logic          proto_err;

   int checks = 0;
   int errors = 0;
   int n_emit;
   int fd_n;
   int fd_at;
   logic [255:0] last_data;
   logic [255:0] bv;
   logic [191:0] pv;
   logic [255:0] ev;

   conv_psum_accumulator dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg_total_pixels  (cfg_total_pixels),
      .bias_valid        (bias_valid),
      .bias_data         (bias_data),
      .conv_valid_in     (conv_valid_in),
      .conv_last_channel (conv_last_channel),
      .psum_in           (psum_in),
      .acc_valid_out     (acc_valid_out),
      .acc_data_out      (acc_data_out),
      .frame_done        (frame_done),
      .ovf_sticky        (ovf_sticky),
      .proto_err         (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] racc(input int v);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
      return r;
   endfunction

   function automatic logic [191:0] rps(input int v);
      logic [191:0] r;
      for (int i = 0; i < 8; i++) r[i*24 +: 24] = v[23:0];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic obs();
      if (acc_valid_out) begin
         n_emit++;
         last_data = acc_data_out;
         if (frame_done) begin
            fd_n++;
            fd_at = n_emit;
         end
      end
   endtask

   task automatic beat(input int p, input logic last);
      conv_valid_in     = 1'b1;
      conv_last_channel = last;
      psum_in           = rps(p);
      tick();
   endtask

   task automatic idle();
      conv_valid_in     = 1'b0;
      conv_last_channel = 1'b0;
      bias_valid        = 1'b0;
      tick();
   endtask

   task automatic load(input int b, input int cfg);
      conv_valid_in     = 1'b0;
      conv_last_channel = 1'b0;
      bias_valid        = 1'b1;
      bias_data         = racc(b);
      cfg_total_pixels  = 16'(cfg);
      tick();
      bias_valid        = 1'b0;
   endtask

   initial begin
      rst_n             = 1'b0;
      cfg_total_pixels  = '0;
      bias_valid        = 1'b0;
      bias_data         = '0;
      conv_valid_in     = 1'b0;
      conv_last_channel = 1'b0;
      psum_in           = '0;
      repeat (3) tick();
      chk("rst_valid", acc_valid_out, 0);
      chk("rst_data", acc_data_out, 0);
      chk("rst_frame", frame_done, 0);
      chk("rst_ovf", ovf_sticky, 0);
      chk("rst_proto", proto_err, 0);
      rst_n = 1'b1;
      tick();

      // 16 beats of +3 on bias 100
      load(100, 1);
      for (int i = 0; i < 16; i++) begin
         beat(3, i == 15);
         if (i == 14) chk("t1_no_early", acc_valid_out, 0);
      end
      chk("t1_valid", acc_valid_out, 1);
      chk("t1_data", acc_data_out, racc(148));
      chk("t1_frame", frame_done, 1);
      chk("t1_proto", proto_err, 0);
      chk("t1_ovf", ovf_sticky, 0);
      idle();
      chk("t1_pulse", acc_valid_out, 0);
      chk("t1_hold", acc_data_out, racc(148));

      // 64 pixels x 16 beats, contiguous
      load(1, 64);
      n_emit = 0; fd_n = 0; fd_at = 0; last_data = '0;
      for (int p = 0; p < 64; p++) begin
         for (int i = 0; i < 16; i++) begin
            beat(p, i == 15);
            obs();
         end
      end
      idle();
      obs();
      chk("t2_emits", n_emit, 64);
      chk("t2_frames", fd_n, 1);
      chk("t2_frame_at", fd_at, 64);
      chk("t2_last", last_data, racc(1 + 16 * 63));

      // saturation both directions
      bv = '0;
      bv[3*32 +: 32] = 32'h7FFF_FFF6;
      bv[0 +: 32]    = 32'h8000_0005;
      pv = '0;
      pv[3*24 +: 24] = 24'd20;
      pv[0 +: 24]    = 24'hFF_FFEC;
      ev = '0;
      ev[3*32 +: 32] = 32'h7FFF_FFFF;
      ev[0 +: 32]    = 32'h8000_0000;
      bias_valid = 1'b1; bias_data = bv; cfg_total_pixels = 16'd1;
      tick();
      bias_valid = 1'b0;
      conv_valid_in = 1'b1; conv_last_channel = 1'b1; psum_in = pv;
      tick();
      chk("t3_sat", acc_data_out, ev);
      chk("t3_ovf", ovf_sticky, 1);
      load(0, 1);
      chk("t3_ovf_clr", ovf_sticky, 0);

      // single ci group, emit every cycle
      load(-5, 0);
      for (int k = 0; k < 10; k++) begin
         beat(k, 1'b1);
         chk("t4_valid", acc_valid_out, 1);
         chk("t4_data", acc_data_out, racc(k - 5));
         chk("t4_frame", frame_done, 1);
      end
      idle();
      chk("t4_stop", acc_valid_out, 0);

      // bias arriving with the first beat is used directly
      bias_valid = 1'b1; bias_data = racc(7); cfg_total_pixels = 16'd1;
      beat(1, 1'b1);
      bias_valid = 1'b0;
      chk("t4_bypass", acc_data_out, racc(8));
      idle();

      // stray last and bias reload mid-pixel
      chk("t5_proto_pre", proto_err, 0);
      load(10, 4);
      beat(2, 1'b0);
      beat(2, 1'b0);
      conv_valid_in = 1'b0; conv_last_channel = 1'b1;
      tick();
      chk("t5_no_emit", acc_valid_out, 0);
      chk("t5_proto", proto_err, 1);
      conv_last_channel = 1'b0;
      bias_valid = 1'b1; bias_data = racc(1000);
      tick();
      bias_valid = 1'b0;
      chk("t5_no_emit2", acc_valid_out, 0);
      beat(2, 1'b0);
      beat(2, 1'b1);
      chk("t5_valid", acc_valid_out, 1);
      chk("t5_old_bias", acc_data_out, racc(18));
      beat(0, 1'b1);
      chk("t5_new_bias", acc_data_out, racc(1000));
      idle();

      // reset in the middle of a pixel
      load(50, 1);
      for (int i = 0; i < 5; i++) beat(4, 1'b0);
      conv_valid_in = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", acc_valid_out, 0);
      chk("t6_rst_data", acc_data_out, 0);
      chk("t6_rst_proto", proto_err, 0);
      chk("t6_rst_frame", frame_done, 0);
      tick();
      rst_n = 1'b1;
      n_emit = 0; fd_n = 0; fd_at = 0; last_data = '0;
      tick();
      obs();
      load(20, 1);
      obs();
      for (int i = 0; i < 16; i++) begin
         beat(1, i == 15);
         obs();
      end
      idle();
      obs();
      chk("t6_emits", n_emit, 1);
      chk("t6_data", last_data, racc(36));

      // beat in IDLE runs with zero bias and flags an error
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      beat(9, 1'b1);
      chk("t7_idle_data", acc_data_out, racc(9));
      chk("t7_idle_proto", proto_err, 1);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
